// File: rtl/pc_unit.sv
// ============================================================================
// Module   : pc_unit
// Brief    : Fetch program counter for the pipelined RISC-V core. It provides:
//            - boot sequencing
//            - prioritised next-PC selection (trap > branch > stall > +4)
//            - redirect target alignment checking
//            - a registered flush pulse
//            - a saturating redirect counter
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module pc_unit #(
  parameter int unsigned XLEN         = 32,
  parameter logic [31:0] RESET_VECTOR = 32'h0000_0000,
  parameter logic [31:0] TRAP_VECTOR  = 32'h0000_0100,
  parameter int unsigned IALIGN       = 4,
  parameter int unsigned CNT_W        = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             stall,
  input  logic             br_taken,
  input  logic [XLEN-1:0]  br_target,
  input  logic             trap,
  output logic [XLEN-1:0]  PC,
  output logic [XLEN-1:0]  PC_Plus4,
  output logic             fetch_valid,
  output logic             flush,
  output logic             misalign,
  output logic [CNT_W-1:0] redirect_cnt
);

  // BOOT is only ever entered through reset; RUN is the steady state.
  typedef enum logic [0:0] {
    ST_BOOT = 1'b0,
    ST_RUN  = 1'b1
  } state_t;

  // Vectors are supplied as 32-bit values and resized to the PC width.
  localparam logic [XLEN-1:0]  c_reset_pc = XLEN'(RESET_VECTOR);
  localparam logic [XLEN-1:0]  c_trap_pc  = XLEN'(TRAP_VECTOR);
  localparam logic [CNT_W-1:0] c_cnt_max  = {CNT_W{1'b1}};
  localparam logic [XLEN-1:0]  c_pc_inc   = XLEN'(4);
  localparam logic [CNT_W-1:0] c_cnt_one  = CNT_W'(1);

  state_t           state_q, state_d;
  logic [XLEN-1:0]  pc_q, pc_d;
  logic             fetch_valid_q, fetch_valid_d;
  logic             flush_q, flush_d;
  logic             misalign_q, misalign_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic             w_misaligned;
  logic             w_redirect;
  logic [XLEN-1:0]  w_pc_plus4;

  // A target is misaligned when it is not on an instruction boundary.
  // With compressed support (IALIGN = 2) only bit 0 matters.
  generate
    if (IALIGN == 2) begin : g_ialign2
      assign w_misaligned = br_target[0];
    end else begin : g_ialign4
      assign w_misaligned = |br_target[1:0];
    end
  endgenerate

  // Sequential fetch address; wraps naturally modulo 2^XLEN.
  assign w_pc_plus4 = pc_q + c_pc_inc;

  // Next-state and next-PC selection.
  // Priority is trap > branch (aligned or not) > stall > increment.
  // Redirects win over stall so that a flush is never delayed.
  always_comb begin
    state_d       = state_q;
    pc_d          = pc_q;
    fetch_valid_d = fetch_valid_q;
    flush_d       = 1'b0;
    misalign_d    = 1'b0;
    cnt_d         = cnt_q;
    w_redirect    = 1'b0;

    case (state_q)
      ST_BOOT: begin
        // All requests are ignored during the boot edge. The PC stays at
        // the reset vector so that it becomes the first fetched address.
        state_d       = ST_RUN;
        fetch_valid_d = 1'b1;
      end

      ST_RUN: begin
        fetch_valid_d = 1'b1;
        if (trap) begin
          // A trap masks any simultaneous branch, so no misalign is reported.
          pc_d       = c_trap_pc;
          flush_d    = 1'b1;
          w_redirect = 1'b1;
        end else if (br_taken && !w_misaligned) begin
          pc_d       = br_target;
          flush_d    = 1'b1;
          w_redirect = 1'b1;
        end else if (br_taken) begin
          // A misaligned redirect target is diverted to the trap vector.
          pc_d       = c_trap_pc;
          flush_d    = 1'b1;
          misalign_d = 1'b1;
          w_redirect = 1'b1;
        end else if (stall) begin
          pc_d = pc_q;
        end else begin
          pc_d = w_pc_plus4;
        end
      end

      default: begin
        state_d       = ST_BOOT;
        pc_d          = c_reset_pc;
        fetch_valid_d = 1'b0;
      end
    endcase

    // The performance counter sticks at all-ones instead of wrapping.
    if (w_redirect && (cnt_q != c_cnt_max)) begin
      cnt_d = cnt_q + c_cnt_one;
    end
  end

  // State and output registers, cleared asynchronously by the active-low reset.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q       <= ST_BOOT;
      pc_q          <= c_reset_pc;
      fetch_valid_q <= 1'b0;
      flush_q       <= 1'b0;
      misalign_q    <= 1'b0;
      cnt_q         <= '0;
    end else begin
      state_q       <= state_d;
      pc_q          <= pc_d;
      fetch_valid_q <= fetch_valid_d;
      flush_q       <= flush_d;
      misalign_q    <= misalign_d;
      cnt_q         <= cnt_d;
    end
  end

  assign PC           = pc_q;
  assign PC_Plus4     = w_pc_plus4;
  assign fetch_valid  = fetch_valid_q;
  assign flush        = flush_q;
  assign misalign     = misalign_q;
  assign redirect_cnt = cnt_q;

endmodule

`default_nettype wire

// File: tb/tb_pc_unit.sv
// ============================================================================
// Module   : tb_pc_unit
// Brief    : Scoreboard bench for pc_unit. It drives directed vectors on two
//            instances:
//            - IALIGN=4 with CNT_W=3
//            - IALIGN=2 with default CNT_W
//            Expected values are queued and compared by a separate monitor.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_pc_unit;

  typedef struct {
    bit          sel;
    logic [31:0] pc;
    logic        fv;
    logic        fl;
    logic        mi;
    logic [31:0] cnt;
    string       name;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_m = 1'b0;
  logic        rst_a = 1'b0;
  logic        stall = 1'b0;
  logic        br_taken = 1'b0;
  logic [31:0] br_target = 32'h0;
  logic        trap = 1'b0;

  logic [31:0] pc_m, pc4_m, pc_a, pc4_a;
  logic        fv_m, fl_m, mi_m, fv_a, fl_a, mi_a;
  logic [2:0]  cnt_m;
  logic [15:0] cnt_a;

  exp_t exp_q[$];
  bit   cur_sel = 1'b0;
  int   n_tests = 0;
  int   n_fail  = 0;
  event ev_chk;

  always #5 clk = ~clk;

  pc_unit #(
    .XLEN(32), .RESET_VECTOR(32'h0), .TRAP_VECTOR(32'h100), .IALIGN(4), .CNT_W(3)
  ) u_dut_m (
    .clk(clk), .rst(rst_m), .stall(stall), .br_taken(br_taken),
    .br_target(br_target), .trap(trap), .PC(pc_m), .PC_Plus4(pc4_m),
    .fetch_valid(fv_m), .flush(fl_m), .misalign(mi_m), .redirect_cnt(cnt_m)
  );

  pc_unit #(
    .XLEN(32), .RESET_VECTOR(32'h0), .TRAP_VECTOR(32'h100), .IALIGN(2), .CNT_W(16)
  ) u_dut_a (
    .clk(clk), .rst(rst_a), .stall(stall), .br_taken(br_taken),
    .br_target(br_target), .trap(trap), .PC(pc_a), .PC_Plus4(pc4_a),
    .fetch_valid(fv_a), .flush(fl_a), .misalign(mi_a), .redirect_cnt(cnt_a)
  );

  function automatic void chk(string nm, string fld, logic [31:0] act, logic [31:0] req);
    n_tests++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s.%s: got %h required %h", nm, fld, act, req);
    end
  endfunction

  // Monitor: compares every queued expectation against the selected DUT.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk or ev_chk);
      while (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        if (!e.sel) begin
          chk(e.name, "pc",    pc_m,          e.pc);
          chk(e.name, "pc4",   pc4_m,         e.pc + 32'd4);
          chk(e.name, "fv",    {31'd0, fv_m}, {31'd0, e.fv});
          chk(e.name, "flush", {31'd0, fl_m}, {31'd0, e.fl});
          chk(e.name, "mis",   {31'd0, mi_m}, {31'd0, e.mi});
          chk(e.name, "cnt",   {29'd0, cnt_m}, e.cnt);
        end else begin
          chk(e.name, "pc",    pc_a,          e.pc);
          chk(e.name, "pc4",   pc4_a,         e.pc + 32'd4);
          chk(e.name, "fv",    {31'd0, fv_a}, {31'd0, e.fv});
          chk(e.name, "flush", {31'd0, fl_a}, {31'd0, e.fl});
          chk(e.name, "mis",   {31'd0, mi_a}, {31'd0, e.mi});
          chk(e.name, "cnt",   {16'd0, cnt_a}, e.cnt);
        end
      end
    end
  end

  function automatic void push(logic [31:0] pc, logic fv, logic fl, logic mi,
                               int cnt, string nm);
    exp_t e;
    e.sel  = cur_sel;
    e.pc   = pc;
    e.fv   = fv;
    e.fl   = fl;
    e.mi   = mi;
    e.cnt  = cnt;
    e.name = nm;
    exp_q.push_back(e);
  endfunction

  // One clock: apply inputs, queue the state expected after the edge.
  task automatic step(input logic s, input logic b, input logic [31:0] t,
                      input logic tr, input logic [31:0] pc, input logic fv,
                      input logic fl, input logic mi, input int cnt,
                      input string nm);
    stall     = s;
    br_taken  = b;
    br_target = t;
    trap      = tr;
    @(posedge clk);
    push(pc, fv, fl, mi, cnt, nm);
    @(negedge clk);
    #1;
  endtask

  initial begin
    @(negedge clk);
    #1;
    cur_sel = 1'b0;

    // Reset and sequential run
    repeat (3) step(0, 0, 32'h0, 0, 32'h0, 0, 0, 0, 0, "reset");
    rst_m = 1'b1;
    step(0, 0, 32'h0, 0, 32'h0,  1, 0, 0, 0, "boot");
    step(0, 0, 32'h0, 0, 32'h4,  1, 0, 0, 0, "seq4");
    step(0, 0, 32'h0, 0, 32'h8,  1, 0, 0, 0, "seq8");
    step(0, 0, 32'h0, 0, 32'hC,  1, 0, 0, 0, "seqC");
    step(0, 0, 32'h0, 0, 32'h10, 1, 0, 0, 0, "seq10");

    // Stall holds; redirect overrides stall
    step(1, 0, 32'h0,  0, 32'h10, 1, 0, 0, 0, "stall1");
    step(1, 0, 32'h0,  0, 32'h10, 1, 0, 0, 0, "stall2");
    step(1, 1, 32'h40, 0, 32'h40, 1, 1, 0, 1, "stall_br");
    step(0, 0, 32'h0,  0, 32'h44, 1, 0, 0, 1, "after_br");

    // Misaligned target is diverted to the trap vector
    step(0, 1, 32'h42, 0, 32'h100, 1, 1, 1, 2, "misalign");
    step(0, 0, 32'h0,  0, 32'h104, 1, 0, 0, 2, "mis_clear");

    // Trap beats branch; no misalign even with a misaligned target
    step(0, 1, 32'h80, 1, 32'h100, 1, 1, 0, 3, "trap_br");
    step(0, 1, 32'h82, 1, 32'h100, 1, 1, 0, 4, "trap_brmis");
    step(0, 0, 32'h0,  0, 32'h104, 1, 0, 0, 4, "after_trap");

    // PC wraps modulo 2^32
    step(0, 1, 32'hFFFF_FFF8, 0, 32'hFFFF_FFF8, 1, 1, 0, 5, "br_high");
    step(0, 0, 32'h0, 0, 32'hFFFF_FFFC, 1, 0, 0, 5, "seq_top");
    step(0, 0, 32'h0, 0, 32'h0,         1, 0, 0, 5, "wrap");

    // Nine back-to-back redirects: flush stays high, counter sticks at 7
    for (int i = 0; i < 9; i++) begin
      step(0, 1, 32'h200 + 32'(4 * i), 0, 32'h200 + 32'(4 * i), 1, 1, 0,
           (6 + i > 7) ? 7 : 6 + i, "b2b");
    end
    step(0, 0, 32'h0, 0, 32'h224, 1, 0, 0, 7, "b2b_end");

    // Async reset in the middle of a flush cycle
    step(0, 1, 32'h300, 0, 32'h300, 1, 1, 0, 7, "pre_rst");
    #2;
    rst_m = 1'b0;
    #1;
    push(32'h0, 0, 0, 0, 0, "async_rst");
    ->ev_chk;

    // Trap while in reset and during BOOT is ignored
    step(1, 1, 32'h84, 1, 32'h0, 0, 0, 0, 0, "rst_trap");
    rst_m = 1'b1;
    step(1, 1, 32'h84, 1, 32'h0,   1, 0, 0, 0, "boot_trap");
    step(0, 0, 32'h0,  1, 32'h100, 1, 1, 0, 1, "run_trap");
    step(0, 0, 32'h0,  0, 32'h104, 1, 0, 0, 1, "run_seq");

    // IALIGN = 2 instance: 0x42 is aligned, 0x43 is not
    rst_m   = 1'b0;
    cur_sel = 1'b1;
    step(0, 0, 32'h0, 0, 32'h0, 0, 0, 0, 0, "a_reset");
    rst_a = 1'b1;
    step(0, 0, 32'h0,  0, 32'h0,   1, 0, 0, 0, "a_boot");
    step(0, 1, 32'h42, 0, 32'h42,  1, 1, 0, 1, "a_br42");
    step(0, 1, 32'h43, 0, 32'h100, 1, 1, 1, 2, "a_br43");
    step(0, 0, 32'h0,  0, 32'h104, 1, 0, 0, 2, "a_seq");

    repeat (2) @(negedge clk);
    #1;
    chk("drain", "queue", 32'(exp_q.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
